// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit general-purpose data/shift register.
// It supports parallel load, clear and set, single-step shift and rotate, and a
// multi-cycle shift-by-N engine that reports progress through busy and done.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous, active-high reset
//   en      single-step enable (accepted only while idle)
//   mode    0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 CLR, 7 SET
//   d       parallel load data
//   sin     serial input: SHL shifts it into bit 0, SHR into bit WIDTH-1
//   start   launches a multi-step shift of amt steps (accepted only while idle)
//   amt     number of steps for start
//   q       register value
//   q_bar   always ~q
//   sout_l  q[WIDTH-1]
//   sout_r  q[0]
//   busy    a multi-step operation is in progress
//   done    one-cycle pulse when a multi-step operation completes
module univ_shift_reg #(
    parameter int unsigned       WIDTH   = 8,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [2:0]               mode,
    input  logic [WIDTH-1:0]         d,
    input  logic                     sin,
    input  logic                     start,
    input  logic [$clog2(WIDTH):0]   amt,
    output logic [WIDTH-1:0]         q,
    output logic [WIDTH-1:0]         q_bar,
    output logic                     sout_l,
    output logic                     sout_r,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned AMT_W = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROL  = 3'd4,
        MODE_ROR  = 3'd5,
        MODE_CLR  = 3'd6,
        MODE_SET  = 3'd7
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic [AMT_W-1:0]   count_q, count_d;
    mode_e              op_q,    op_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    // One application of an operation to the current value.
    function automatic logic [WIDTH-1:0] step_op(
        input mode_e            op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] din,
        input logic             s
    );
        logic [WIDTH-1:0] res;
        res = cur;
        case (op)
            MODE_HOLD: res = cur;
            MODE_LOAD: res = din;
            MODE_SHL:  res = {cur[WIDTH-2:0], s};
            MODE_SHR:  res = {s, cur[WIDTH-1:1]};
            MODE_ROL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_ROR:  res = {cur[0], cur[WIDTH-1:1]};
            MODE_CLR:  res = '0;
            MODE_SET:  res = '1;
            default:   res = cur;
        endcase
        return res;
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= RST_VAL;
            count_q <= '0;
            op_q    <= MODE_HOLD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: idle accepts start (priority) or en; shift runs the latched op.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        op_d    = op_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (amt == '0) begin
                        done_d = 1'b1;
                    end else if (mode_e'(mode) inside {MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR}) begin
                        state_d = ST_SHIFT;
                        count_d = amt;
                        op_d    = mode_e'(mode);
                        busy_d  = 1'b1;
                    end
                end else if (en) begin
                    data_d = step_op(mode_e'(mode), data_q, d, sin);
                end
            end
            ST_SHIFT: begin
                data_d  = step_op(op_q, data_q, d, sin);
                count_d = count_q - AMT_W'(1);
                if (count_q == AMT_W'(1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign q      = data_q;
    assign q_bar  = ~data_q;
    assign sout_l = data_q[WIDTH-1];
    assign sout_r = data_q[0];
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
